// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the iterative ALU execute stage.
//   alu_op_e : ALU control codes produced by the decoder (0-8, 9-15 unused)
//   state_e  : execute FSM states
//   is_shift : true for the codes executed one bit per cycle
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Shift amounts come from operand B bits [4:0]
    localparam int SHAMT_W = 5;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core -- combinational single-cycle ALU operations.
//   op_i  : ALU control code
//   a_i   : operand A
//   b_i   : operand B
//   res_o : result; shift codes and unused codes 9-15 return zero here
//           (shifts are executed iteratively by the parent)
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o
);

    // Single-cycle operation select; arithmetic wraps modulo 2^WIDTH
    always_comb begin
        res_o = {WIDTH{1'b0}};
        case (op_i)
            ALU_ADD: res_o = a_i + b_i;
            ALU_SUB: res_o = a_i - b_i;
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_XOR: res_o = a_i ^ b_i;
            ALU_SLT: res_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: res_o = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_iter_exec.sv
// ---------------------------------------------------------------------------
// alu_iter_exec -- ALU execute stage with bit-serial shifts.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   valid_i/ready_o: operation handshake (ready only in IDLE)
//   aluControl_i   : ALU control code, srcA_i/srcB_i operands
//   flush_i        : synchronous abort, overrides everything else
//   valid_o/ready_i: result handshake, result_o/zero_o held until accepted
// Non-shift codes finish one cycle after transfer; shifts take 1 + shamt.
// ---------------------------------------------------------------------------
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       aluControl_i,
    input  logic [WIDTH-1:0] srcA_i,
    input  logic [WIDTH-1:0] srcB_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;   // also serves as the shift register
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     core_res_s;
    logic [WIDTH-1:0]     shifted_s;
    logic [SHAMT_W-1:0]   shamt_s;

    assign shamt_s = srcB_i[SHAMT_W-1:0];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i  (aluControl_i),
        .a_i   (srcA_i),
        .b_i   (srcB_i),
        .res_o (core_res_s)
    );

    // One-bit step of the shift in progress, selected by the latched code
    always_comb begin
        shifted_s = result_q;
        case (op_q)
            ALU_SLL: shifted_s = {result_q[WIDTH-2:0], 1'b0};
            ALU_SRL: shifted_s = {1'b0, result_q[WIDTH-1:1]};
            ALU_SRA: shifted_s = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: shifted_s = result_q;
        endcase
    end

    // FSM next-state and datapath update; flush wins over any handshake
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        valid_d  = valid_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            cnt_d   = {SHAMT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        op_d = aluControl_i;
                        if (is_shift(aluControl_i)) begin
                            result_d = srcA_i;
                            cnt_d    = shamt_s;
                            if (shamt_s != {SHAMT_W{1'b0}}) begin
                                state_d = ST_SHIFT;
                            end else begin
                                state_d = ST_DONE;
                                valid_d = 1'b1;
                            end
                        end else begin
                            result_d = core_res_s;
                            state_d  = ST_DONE;
                            valid_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    result_d = shifted_s;
                    cnt_d    = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            result_q <= {WIDTH{1'b0}};
            cnt_q    <= {SHAMT_W{1'b0}};
            op_q     <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = (result_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_iter_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_iter_exec -- scoreboard bench for alu_iter_exec.
// The driver pushes the expected result and latency when it issues an
// operation; a negedge monitor pops and compares whenever valid_o rises.
// ---------------------------------------------------------------------------
module tb_alu_iter_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    logic          ready_o;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          flush;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  result_o;
    logic          zero_o;

    always #5 clk = ~clk;

    alu_iter_exec #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .aluControl_i (alu_ctrl),
        .srcA_i       (src_a),
        .srcB_i       (src_b),
        .flush_i      (flush),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .zero_o       (zero_o)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        int           lat;
        int           issue;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pop on the first cycle of each result, then check it holds
    logic         seen = 1'b0;
    logic [W-1:0] held;
    exp_t         e;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_o === 1'b1) begin
            check("ready_low_in_done", {31'd0, ready_o}, 32'd0);
            if (!seen) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, ".result"}, result_o, e.res);
                    check({e.name, ".zero"}, {31'd0, zero_o}, {31'd0, e.z});
                    check({e.name, ".latency"}, cyc - e.issue, e.lat);
                end
                seen = 1'b1;
                held = result_o;
            end else begin
                check("hold_stable", result_o, held);
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic do_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                         input bit expect_result);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", {31'd0, ready_o}, 32'd1);
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        valid_i  = 1'b1;
        if (expect_result) begin
            x.res = exp; x.z = (exp == 32'd0); x.lat = lat; x.issue = cyc; x.name = nm;
            sb.push_back(x);
        end
        @(negedge clk);
        valid_i  = 1'b0;
        alu_ctrl = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || !ready_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("done_timeout", sb.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".valid"}, {31'd0, valid_o}, 32'd0);
        check({nm, ".result"}, result_o, 32'd0);
        check({nm, ".zero"}, {31'd0, zero_o}, 32'd1);
        check({nm, ".ready"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        flush    = 1'b0;
        alu_ctrl = 4'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single-cycle operations
        do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1'b1); wait_done();
        do_op("slt_neg",  4'd5, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001, 1, 1'b1); wait_done();
        do_op("slt_swap", 4'd5, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000, 1, 1'b1); wait_done();
        do_op("and",      4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 1'b1); wait_done();
        do_op("xor",      4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1, 1'b1); wait_done();
        do_op("code12",   4'd12, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 1'b1); wait_done();

        // Iterative shifts
        do_op("sra4",  4'd8, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5, 1'b1); wait_done();
        do_op("sra0",  4'd8, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1, 1'b1); wait_done();
        do_op("sll3",  4'd6, 32'h0000_0001, 32'h0000_0003, 32'h0000_0008, 4, 1'b1); wait_done();
        do_op("srl1",  4'd7, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 2, 1'b1); wait_done();

        // Backpressure: result held three cycles with ready_i low
        ready_i = 1'b0;
        do_op("or_bp", 4'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1, 1'b1);
        n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) begin
            @(negedge clk);
            check("bp_valid_held", {31'd0, valid_o}, 32'd1);
            check("bp_ready_low", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        wait_done();

        // Flush during a long shift
        do_op("sll_flush", 4'd6, 32'h0000_0001, 32'h0000_001F, 32'h0, 0, 1'b0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", {31'd0, ready_o}, 32'd1);
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        repeat (40) @(negedge clk);
        do_op("sub_neg", 4'd1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, 1'b1); wait_done();

        // Reset in the middle of a shift
        do_op("srl_rst", 4'd7, 32'h0000_00F0, 32'h0000_0014, 32'h0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_ready", {31'd0, ready_o}, 32'd1);
        do_op("xor_after", 4'd4, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 1, 1'b1); wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
